// File: rtl/wb_cmd_pkg.sv
// Shared types and constants for the command-to-Wishbone initiator.
package wb_cmd_pkg;
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;
  localparam int TO_CNT_W = 8;
endpackage

// File: rtl/wb_cmd_timeout.sv
// Bus-cycle watchdog: counts strobe cycles and flags the last one allowed without ack.
module wb_cmd_timeout
  import wb_cmd_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic wb_clk_i,
  input  logic wb_rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam logic [TO_CNT_W-1:0] LAST = TO_CNT_W'(TIMEOUT - 1);

  logic [TO_CNT_W-1:0] cnt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || clr) cnt_q <= '0;
    else if (en)         cnt_q <= cnt_q + 1'b1;
  end

  // Counter holds k-1 during the k-th strobe cycle, so strobe stays up TIMEOUT cycles.
  assign expired = en && (cnt_q == LAST);
endmodule

// File: rtl/wb_cmd_master.sv
// Single-outstanding Wishbone initiator: one command in, one classic cycle, one response out.
module wb_cmd_master
  import wb_cmd_pkg::*;
#(
  parameter int ADR_W   = 3,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [DAT_W-1:0] resp_dat_o,
  output logic             resp_err_o,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [DAT_W-1:0] wb_dat_o,
  input  logic [DAT_W-1:0] wb_dat_i,
  input  logic             wb_ack_i
);
  state_e state_q, state_d;
  logic   accept, bus_done, to_expired;

  wb_cmd_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .clr      (accept),
    .en       (state_q == BUS),
    .expired  (to_expired)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bus_done = 1'b0;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        accept  = 1'b1;
        state_d = BUS;
      end
      BUS: if (wb_ack_i || to_expired) begin
        bus_done = 1'b1;
        state_d  = RESP;
      end
      RESP: if (resp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      resp_dat_o <= '0;
      resp_err_o <= 1'b0;
    end else begin
      if (accept) begin
        wb_we_o  <= cmd_we_i;
        wb_adr_o <= cmd_adr_i;
        wb_dat_o <= cmd_dat_i;
      end
      // Ack beats timeout when both land on the same edge.
      if (bus_done) begin
        resp_dat_o <= (wb_ack_i && !wb_we_o) ? wb_dat_i : '0;
        resp_err_o <= !wb_ack_i;
      end
    end
  end

  assign cmd_ready_o  = (state_q == IDLE);
  assign wb_cyc_o     = (state_q == BUS);
  assign wb_stb_o     = (state_q == BUS);
  assign resp_valid_o = (state_q == RESP);
endmodule

// File: tb/tb_wb_cmd_master.sv
// Scoreboard bench for wb_cmd_master against a registered-ack 8-byte register slave.
module tb_wb_cmd_master;
  localparam int ADR_W = 3, DAT_W = 8, TIMEOUT = 15;

  logic             clk = 0, rst = 1;
  logic             cmd_valid = 0, cmd_ready, cmd_we = 0;
  logic [ADR_W-1:0] cmd_adr = '0;
  logic [DAT_W-1:0] cmd_dat = '0;
  logic             resp_valid, resp_ready = 1, resp_err;
  logic [DAT_W-1:0] resp_dat;
  logic             cyc, stb, we, ack_q = 0, ack_en = 1;
  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_o, dat_i;

  logic [7:0] mem [8];
  logic [8:0] sb_q [$];
  int n_vec = 0, n_miss = 0;
  int stb_cur = 0, last_len = 0, bursts = 0, acks = 0, we_cycles = 0;

  always #5 clk = ~clk;

  wb_cmd_master #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_dat_o(resp_dat), .resp_err_o(resp_err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_dat_o(dat_o), .wb_dat_i(dat_i), .wb_ack_i(ack_q)
  );

  // Slave: ack is a registered copy of strobe, so it lingers one cycle after.
  assign dat_i = mem[adr];
  always @(posedge clk) begin
    ack_q <= ack_en && cyc && stb;
    if (cyc && stb && we) mem[adr] <= dat_o;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Bus/response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (stb) stb_cur++;
    else if (stb_cur > 0) begin last_len = stb_cur; stb_cur = 0; bursts++; end
    if (cyc && stb && ack_q) acks++;
    if (cyc && stb && we) we_cycles++;
    if (!rst && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) chk("spurious_resp", 1, 0);
      else begin
        logic [8:0] e;
        e = sb_q.pop_front();
        chk("resp_dat", resp_dat, e[7:0]);
        chk("resp_err", resp_err, e[8]);
      end
    end
  end

  task automatic send(input logic w, input logic [2:0] a, input logic [7:0] d,
                      input logic [7:0] edat, input logic eerr, input bit expect_resp);
    bit ok = 0;
    cmd_valid = 1; cmd_we = w; cmd_adr = a; cmd_dat = d;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) chk("cmd_accept_timeout", 0, 1);
    else if (expect_resp) sb_q.push_back({eerr, edat});
    @(posedge clk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_resp();
    bit ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (sb_q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk("resp_wait_timeout", sb_q.size(), 0);
    @(negedge clk); #1;
  endtask

  initial begin
    int a0, b0, w0;
    logic [7:0] held;
    bit stable;
    mem[0] = 8'hA5; mem[1] = 8'h5A; mem[2] = 8'h03; mem[3] = 8'hC3;
    for (int i = 4; i < 8; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp", {resp_err, resp_dat}, 0);
    chk("rst_cyc_stb_we", {cyc, stb, we}, 0);
    chk("rst_adr_dat", {adr, dat_o}, 0);

    // Read revision register.
    a0 = acks;
    send(0, 3'd2, 8'h00, 8'h03, 0, 1);
    wait_resp();
    chk("rd_stb_len", last_len, 2);
    chk("rd_acks", acks - a0, 1);

    // Write then read back; we only asserted during the write strobe.
    w0 = we_cycles;
    send(1, 3'd6, 8'h01, 8'h00, 0, 1);
    wait_resp();
    chk("wr_we_cycles", we_cycles - w0, 2);
    chk("wr_mem", mem[6], 8'h01);
    w0 = we_cycles;
    send(0, 3'd6, 8'h00, 8'h01, 0, 1);
    wait_resp();
    chk("rd_we_cycles", we_cycles - w0, 0);

    // Timeout with no ack, then normal recovery.
    ack_en = 0;
    send(0, 3'd1, 8'h00, 8'h00, 1, 1);
    wait_resp();
    chk("to_stb_len", last_len, TIMEOUT);
    ack_en = 1;
    send(0, 3'd3, 8'h00, 8'hC3, 0, 1);
    wait_resp();
    chk("post_to_stb_len", last_len, 2);

    // Response backpressure.
    b0 = bursts;
    resp_ready = 0;
    send(0, 3'd0, 8'h00, 8'hA5, 0, 1);
    for (int i = 0; i < 20 && !resp_valid; i++) @(negedge clk);
    held = resp_dat; stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!resp_valid || resp_dat !== held || cmd_ready || cyc || stb) stable = 0;
    end
    chk("bp_held_dat", held, 8'hA5);
    chk("bp_stable", stable, 1);
    resp_ready = 1;
    wait_resp();
    chk("bp_bursts", bursts - b0, 1);

    // Reset during the first strobe cycle.
    send(0, 3'd1, 8'h00, 8'h00, 0, 0);
    chk("rst_mid_stb", stb, 1);
    rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst_mid_cyc_stb", {cyc, stb}, 0);
    chk("rst_mid_ready", cmd_ready, 1);
    stable = 1;
    repeat (4) begin @(negedge clk); if (resp_valid) stable = 0; end
    chk("rst_mid_no_resp", stable, 1);
    chk("rst_mid_sb_empty", sb_q.size(), 0);

    // Back-to-back reads.
    a0 = acks; b0 = bursts;
    for (int i = 0; i < 4; i++) send(0, 3'(i), 8'h00, mem[i], 0, 1);
    wait_resp();
    chk("b2b_acks", acks - a0, 4);
    chk("b2b_bursts", bursts - b0, 4);
    chk("b2b_stb_len", last_len, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Single-outstanding Wishbone initiator that turns a command stream (address, write flag, data) into one classic Wishbone cycle and returns one response (read data or write acknowledgement, with timeout error). It sits between a command source in the CPLD (serial/SelectMAP/config front end) and the 8-bit register slaves on the CPLD Wishbone bus, such as the system block. It tolerates slaves whose ack is a registered copy of strobe. It never drives a bus cycle that is not terminated within a bounded time.

## Interface
Parameters:
- ADR_W, 3, Wishbone address width.
- DAT_W, 8, Wishbone data width.
- TIMEOUT, 15, maximum cycles strobe is held without ack before abort; legal range 1..255.

Ports:
- wb_clk_i  in  1  sole clock; all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid & ready at an edge.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADR_W  target address.
- cmd_dat_i  in  DAT_W  write data (ignored for reads).
- resp_valid_o  out  1  response present.
- resp_ready_i  in  1  response consumed when valid & ready at an edge.
- resp_dat_o  out  DAT_W  captured read data; 0 for writes and errors.
- resp_err_o  out  1  1 = transaction timed out.
- wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
- wb_adr_o  out  ADR_W; wb_dat_o  out  DAT_W; wb_dat_i  in  DAT_W; wb_ack_i  in  1.

## Operation
- States: IDLE, BUS, RESP. Reset state IDLE.
- IDLE: cmd_ready_o=1. On cmd_valid_i: latch we/adr/dat into output registers, clear timeout counter, go BUS.
- BUS: wb_cyc_o=wb_stb_o=1, wb_we_o/adr/dat held stable. Counter increments each cycle.
  - wb_ack_i=1: capture wb_dat_i into resp_dat (reads only; writes load 0), resp_err=0, go RESP.
  - Counter reaches TIMEOUT with no ack: resp_dat=0, resp_err=1, go RESP.
  - Ack and timeout in same cycle: ack wins, err=0.
- RESP: cyc/stb low, resp_valid_o=1, data/err stable until resp_ready_i; then go IDLE.
- wb_ack_i ignored outside BUS (stale ack from registered-ack slaves is not an error).
- cmd_ready_o=0 in BUS and RESP; commands are held upstream, never dropped.
- wb_rst_i at any edge: next state IDLE, in-flight cycle abandoned (cyc/stb low after that edge), pending response discarded, no resp_valid generated.

## Timing
- Reset values: cmd_ready_o=1, resp_valid_o=0, resp_err_o=0, resp_dat_o=0, wb_cyc_o=wb_stb_o=wb_we_o=0, wb_adr_o=0, wb_dat_o=0.
- All outputs registered or decoded directly from state register; no combinational path from inputs to outputs.
- Command accepted at edge E0 -> cyc/stb high after E0.
- Ack sampled high at edge En -> cyc/stb low and resp_valid high after En. With a 1-cycle registered-ack slave: n=2, strobe high exactly 2 cycles.
- Timeout: ack absent -> strobe high exactly TIMEOUT cycles, resp_valid after the TIMEOUT-th BUS edge.
- Response consumed at edge Er -> IDLE after Er; next command accepted at Er+1 earliest. Guarantees ≥2 low-strobe cycles between transactions, so a stale registered ack has cleared.
- Address/data/we change only on command acceptance.

## Structure
- Package wb_cmd_pkg: state encoding (IDLE/BUS/RESP), timeout counter width constant (8 bits, covering TIMEOUT ≤255).
- One sub-module natural: wb_cmd_timeout (clear, enable, terminal-count compare against TIMEOUT). Rest is the FSM plus output/response registers in the top.

## Test plan
- Read vs system block (REV_MAJOR=3): cmd read adr 2 -> stb high 2 cycles, resp_valid with resp_dat=0x03, resp_err=0.
- Write then read: write 0x01 to adr 6, then read adr 6 -> write resp_dat=0x00 err=0, read resp_dat=0x01; wb_we_o=1 only during write BUS.
- Timeout: wb_ack_i tied 0, TIMEOUT=15 -> stb high exactly 15 cycles, resp_err=1, resp_dat=0x00; next command proceeds normally.
- Backpressure: resp_ready_i low 10 cycles after read of adr 0 -> resp held stable, cmd_ready_o=0, cyc/stb low throughout; one transaction only.
- Reset mid-BUS: assert wb_rst_i during first strobe cycle -> cyc/stb low next cycle, no resp_valid, cmd_ready_o=1.
- Back-to-back: 4 queued reads adr 0..3 with resp_ready_i=1 -> 4 responses in order, exactly one ack counted per transaction, no spurious error.
